trend_run_tracker: RTL and testbench

//  Consumes the registered 1-bit "sample increased" flag from the ltu compare stage, one flag per sample.

---
 rtl/trend_run_if.sv | 12 +
 rtl/trend_run_tracker.sv | 87 ++++++++
 tb/tb_trend_run_tracker.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trend_run_if.sv
// Run-length stream from trend_run_tracker to the trend-statistics consumer.
// Plain valid/ready: the head entry is held until run_valid & run_ready.
interface trend_run_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] run_len_out;
  logic             run_valid;
  logic             run_ready;

  modport master (output run_len_out, run_valid, input run_ready);
  modport slave  (input run_len_out, run_valid, output run_ready);
endinterface

// File: rtl/trend_run_tracker.sv
// Measures runs of consecutive rising samples and queues lengths >= MIN_RUN.
// Entry visible one cycle after the terminating flag; drops and flags sticky when queue full.
module trend_run_tracker #(
  parameter int CNT_W      = 8,
  parameter int MIN_RUN    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_in,
  input  logic        inc_in,
  output logic        run_active,
  output logic        drop_out,
  trend_run_if.master run_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_RUN);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] mem [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic accept;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push   = en_in && (state == RUN) && !inc_in && (cnt >= MIN_LEN);
  assign pop    = !empty && run_if.run_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (en_in) begin
      if (inc_in) begin
        state <= RUN;
        if (state == IDLE)
          cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX)
          cnt <= cnt + CNT_W'(1);
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_out <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !accept)
        drop_out <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= cnt;
  end

  assign run_active         = (state == RUN);
  assign run_if.run_valid   = !empty;
  assign run_if.run_len_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_trend_run_tracker.sv
// Randomized and directed bench for trend_run_tracker against a queue-based run-length model.
module tb_trend_run_tracker;

  localparam int CNT_W   = 4;
  localparam int MIN_RUN = 2;
  localparam int DEPTH   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic inc;
  logic run_active;
  logic drop_out;

  trend_run_if #(.CNT_W(CNT_W)) rif ();

  trend_run_tracker #(.CNT_W(CNT_W), .MIN_RUN(MIN_RUN), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_in      (en),
    .inc_in     (inc),
    .run_active (run_active),
    .drop_out   (drop_out),
    .run_if     (rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: completed qualifying runs in arrival order, current run length, drop flag.
  int mq[$];
  int m_len;
  bit m_run;
  bit m_drop;

  task automatic model_clear();
    mq.delete();
    m_len  = 0;
    m_run  = 0;
    m_drop = 0;
  endtask

  task automatic step(input bit e, input bit i, input bit r);
    bit pop;
    bit push;
    bit was_full;
    en = e;
    inc = i;
    rif.run_ready = r;
    pop      = (mq.size() > 0) && r;
    push     = e && m_run && !i && (m_len >= MIN_RUN);
    was_full = (mq.size() == DEPTH);
    @(posedge clk);
    if (pop) mq.delete(0);
    if (push) begin
      if (!was_full || pop) mq.push_back(m_len);
      else m_drop = 1;
    end
    if (e) begin
      if (i) begin
        m_len = m_run ? ((m_len < CMAX) ? m_len + 1 : CMAX) : 1;
        m_run = 1;
      end else begin
        m_run = 0;
        m_len = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0;
    inc = 0;
    rif.run_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 0;
    inc = 0;
    rif.run_ready = 0;
    model_clear();
    #3;
    checks++;
    if ({run_active, drop_out, rif.run_valid, rif.run_len_out} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%b drop=%b vld=%b len=%0d required all 0",
               run_active, drop_out, rif.run_valid, rif.run_len_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({run_active, drop_out, rif.run_valid} !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got act=%b drop=%b vld=%b required 0", run_active, drop_out, rif.run_valid);
    end
  endtask

  task automatic test_basic();
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    checks++;
    if (run_active !== 1'b1) begin
      errors++; $display("FAIL basic_active: got %b required 1", run_active);
    end
    step(1, 0, 0);
    checks++;
    if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'd3) begin
      errors++; $display("FAIL basic_len: got vld=%b len=%0d required vld=1 len=3", rif.run_valid, rif.run_len_out);
    end
    step(0, 0, 1);
    checks++;
    if (rif.run_valid !== 1'b0 || mq.size() != 0) begin
      errors++; $display("FAIL basic_popped: got vld=%b required 0", rif.run_valid);
    end
  endtask

  task automatic test_min_run();
    step(1, 1, 0); step(1, 0, 0);
    checks++;
    if (rif.run_valid !== 1'b0) begin
      errors++; $display("FAIL min_run_short: got vld=%b required 0", rif.run_valid);
    end
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    checks++;
    if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'd2) begin
      errors++; $display("FAIL min_run_two: got vld=%b len=%0d required vld=1 len=2", rif.run_valid, rif.run_len_out);
    end
    step(0, 0, 1);
  endtask

  task automatic test_drop();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    end
    checks++;
    if (drop_out !== 1'b1 || m_drop != 1) begin
      errors++; $display("FAIL drop_flag: got %b required 1", drop_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'd2) begin
        errors++; $display("FAIL drop_drain%0d: got vld=%b len=%0d required vld=1 len=2", k, rif.run_valid, rif.run_len_out);
      end
      step(0, 0, 1);
    end
    checks++;
    if (rif.run_valid !== 1'b0 || drop_out !== 1'b1) begin
      errors++; $display("FAIL drop_after_drain: got vld=%b drop=%b required vld=0 drop=1", rif.run_valid, drop_out);
    end
  endtask

  task automatic test_full_push_pop();
    int exp[4] = '{2, 2, 2, 3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    end
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    // Run of 3 ends in the same cycle the head is popped.
    step(1, 0, 1);
    checks++;
    if (drop_out !== 1'b0 || mq.size() != 4) begin
      errors++; $display("FAIL full_pushpop_drop: got drop=%b required 0", drop_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'(exp[k])) begin
        errors++; $display("FAIL full_pushpop_drain%0d: got vld=%b len=%0d required vld=1 len=%0d",
                           k, rif.run_valid, rif.run_len_out, exp[k]);
      end
      step(0, 0, 1);
    end
    checks++;
    if (rif.run_valid !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_empty: got vld=%b required 0", rif.run_valid);
    end
  endtask

  task automatic test_saturate();
    repeat (20) step(1, 1, 0);
    step(1, 0, 0);
    checks++;
    if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'd15) begin
      errors++; $display("FAIL saturate: got vld=%b len=%0d required vld=1 len=15", rif.run_valid, rif.run_len_out);
    end
    step(0, 0, 1);
  endtask

  task automatic test_async_reset();
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    repeat (5) step(1, 1, 0);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (run_active !== 1'b0 || rif.run_valid !== 1'b0 || rif.run_len_out !== 4'd0) begin
      errors++; $display("FAIL async_reset: got act=%b vld=%b len=%0d required 0",
                         run_active, rif.run_valid, rif.run_len_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 0;
    inc = 0;
    @(negedge clk);
    step(1, 0, 0); step(1, 0, 0);
    checks++;
    if (run_active !== 1'b0 || rif.run_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_release: got act=%b vld=%b required 0", run_active, rif.run_valid);
    end
  endtask

  task automatic test_enable();
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    checks++;
    if (run_active !== 1'b1 || rif.run_valid !== 1'b0) begin
      errors++; $display("FAIL enable_hold: got act=%b vld=%b required act=1 vld=0", run_active, rif.run_valid);
    end
    step(0, 0, 0);
    step(1, 0, 0);
    checks++;
    if (rif.run_valid !== 1'b1 || rif.run_len_out !== 4'd2) begin
      errors++; $display("FAIL enable_len: got vld=%b len=%0d required vld=1 len=2", rif.run_valid, rif.run_len_out);
    end
    step(0, 0, 1);
  endtask

  task automatic test_random();
    bit e;
    bit i;
    bit r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 3) != 0);
      i = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) == 0);
      checks++;
      if (rif.run_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_valid@%0d: got %b required %b", n, rif.run_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        checks++;
        if (rif.run_len_out !== 4'(mq[0])) begin
          errors++; $display("FAIL rand_len@%0d: got %0d required %0d", n, rif.run_len_out, mq[0]);
        end
      end
      checks++;
      if (run_active !== m_run || drop_out !== m_drop) begin
        errors++; $display("FAIL rand_state@%0d: got act=%b drop=%b required act=%b drop=%b",
                           n, run_active, drop_out, m_run, m_drop);
      end
      step(e, i, r);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0;
    inc = 0;
    rif.run_ready = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_min_run();
    test_drop();
    test_full_push_pop();
    test_saturate();
    test_async_reset();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
